flit_demux_1x4: RTL and testbench



---
 rtl/flit_demux_1x4.sv | 128 ++++++++++++
 tb/tb_flit_demux_1x4.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flit_demux_1x4.sv
// -----------------------------------------------------------------------------
// flit_demux_1x4
// Wormhole flit demultiplexer. A single valid/ready flit stream is steered to
// one of four output ports. The head (or single) flit's destination field
// picks the port; the route stays locked until the tail flit has passed.
// Every flit passes through one registered output stage that supports
// drain-and-reload in the same cycle, so the stream runs at one flit per
// cycle. Flits that break the packet framing are accepted, dropped and
// flagged on err.
//
// Ports
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_flit    input flit; [W-1:W-2] type, [W-3:W-4] destination
//   in_valid   in_flit valid
//   in_ready   block accepts in_flit this cycle
//   out_flit   registered flit, shared by all four ports
//   out_valid  one-hot port valid (bit p = flit valid on port p)
//   out_ready  per-port downstream ready
//   busy       route locked (mid-packet)
//   err        one-cycle pulse when a protocol-violating flit is dropped
// -----------------------------------------------------------------------------
module flit_demux_1x4 #(
   parameter int flit_width = 12
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [flit_width-1:0] in_flit,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [flit_width-1:0] out_flit,
   output logic [3:0]            out_valid,
   input  logic [3:0]            out_ready,
   output logic                  busy,
   output logic                  err
);

   typedef enum logic {IDLE, LOCKED} state_t;

   localparam logic [1:0] T_BODY   = 2'b00;
   localparam logic [1:0] T_HEAD   = 2'b01;
   localparam logic [1:0] T_TAIL   = 2'b10;
   localparam logic [1:0] T_SINGLE = 2'b11;

   function automatic logic [3:0] port_onehot(input logic [1:0] p);
      logic [3:0] oh;
      oh    = 4'b0000;
      oh[p] = 1'b1;
      return oh;
   endfunction

   state_t                state;
   logic [1:0]            lock_port;
   logic                  vld_p1;
   logic [1:0]            port_p1;
   logic [flit_width-1:0] flit_p1;
   logic                  err_p1;

   logic [1:0] ftype;
   logic [1:0] dest;
   logic       accept;
   logic       legal;
   logic [1:0] tgt_port;

   assign ftype = in_flit[flit_width-1:flit_width-2];
   assign dest  = in_flit[flit_width-3:flit_width-4];

   // Ready only looks at the occupied port, never at the incoming flit, so
   // dropped flits drain at the same rate as legal ones.
   assign in_ready = !vld_p1 || out_ready[port_p1];
   assign accept   = in_valid && in_ready;

   // Legality and target port depend on whether a route is currently held.
   always_comb begin
      legal    = 1'b0;
      tgt_port = lock_port;
      if (state == IDLE) begin
         legal    = (ftype == T_HEAD) || (ftype == T_SINGLE);
         tgt_port = dest;
      end else begin
         legal    = (ftype == T_BODY) || (ftype == T_TAIL);
         tgt_port = lock_port;
      end
   end

   // ---- output stage (p1): route FSM, flit/port register, error pulse ----
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         lock_port <= 2'd0;
         vld_p1    <= 1'b0;
         port_p1   <= 2'd0;
         flit_p1   <= '0;
         err_p1    <= 1'b0;
      end else begin
         err_p1 <= accept && !legal;

         if (accept && legal) begin
            vld_p1  <= 1'b1;
            port_p1 <= tgt_port;
            flit_p1 <= in_flit;
         end else if (vld_p1 && out_ready[port_p1]) begin
            vld_p1  <= 1'b0;
         end

         if (accept && legal) begin
            case (state)
               IDLE: begin
                  if (ftype == T_HEAD) begin
                     lock_port <= dest;
                     state     <= LOCKED;
                  end
               end
               LOCKED: begin
                  if (ftype == T_TAIL) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign out_flit  = flit_p1;
   assign out_valid = vld_p1 ? port_onehot(port_p1) : 4'b0000;
   assign busy      = (state == LOCKED);
   assign err       = err_p1;

endmodule

// File: tb/tb_flit_demux_1x4.sv
module tb_flit_demux_1x4;

   logic        clk;
   logic        reset_n;
   logic [11:0] in_flit;
   logic        in_valid;
   logic        in_ready;
   logic [11:0] out_flit;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic        busy;
   logic        err;

   int checks;
   int failures;

   flit_demux_1x4 #(.flit_width(12)) dut (
      .clk(clk), .reset_n(reset_n), .in_flit(in_flit), .in_valid(in_valid),
      .in_ready(in_ready), .out_flit(out_flit), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a packet-level view. 'route' is the port a packet is
   // travelling to (-1 between packets); 'q' holds flits waiting to leave.
   typedef struct {
      logic [11:0] flit;
      int          port;
   } item_t;

   item_t q[$];
   int    route;
   bit    m_err;

   function automatic bit mdl_ready();
      return (q.size() == 0) || out_ready[q[0].port];
   endfunction

   function automatic logic [3:0] mdl_ovalid();
      logic [3:0] v;
      v = 4'b0000;
      if (q.size() != 0) v[q[0].port] = 1'b1;
      return v;
   endfunction

   // Advance one clock and update the model from the inputs seen at the edge.
   task automatic tick();
      bit          acc, drained, rst;
      logic [11:0] f;
      logic [1:0]  t;
      item_t       it;
      rst     = !reset_n;
      acc     = in_valid && mdl_ready();
      drained = (q.size() != 0) && out_ready[q[0].port];
      f       = in_flit;
      t       = f[11:10];
      @(posedge clk);
      if (rst) begin
         q.delete();
         route = -1;
         m_err = 0;
      end else begin
         if (drained) void'(q.pop_front());
         m_err = 0;
         if (acc) begin
            if (route < 0) begin
               if (t == 2'b01 || t == 2'b11) begin
                  it.flit = f; it.port = int'(f[9:8]);
                  q.push_back(it);
                  if (t == 2'b01) route = int'(f[9:8]);
               end else m_err = 1;
            end else begin
               if (t == 2'b00 || t == 2'b10) begin
                  it.flit = f; it.port = route;
                  q.push_back(it);
                  if (t == 2'b10) route = -1;
               end else m_err = 1;
            end
         end
      end
      #1;
   endtask

   task automatic send(input logic [11:0] f);
      in_flit = f; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; in_valid = 1'b0; in_flit = '0; out_ready = 4'hF;
      tick(); tick();
      reset_n = 1'b1;
      #1;
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL reset_ovalid got=%b exp=0000", out_valid); end
      checks++; if (out_flit !== 12'h000) begin failures++; $display("FAIL reset_oflit got=%h exp=000", out_flit); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", in_ready); end
   endtask

   task automatic test_wormhole();
      logic [11:0] pk [3];
      pk[0] = 12'h6AB; pk[1] = 12'h0CD; pk[2] = 12'h8EF;
      out_ready = 4'hF;
      for (int i = 0; i < 3; i++) begin
         send(pk[i]);
         checks++; if (out_valid !== 4'b0100) begin failures++; $display("FAIL worm_ovalid%0d got=%b exp=0100", i, out_valid); end
         checks++; if (out_flit !== pk[i]) begin failures++; $display("FAIL worm_oflit%0d got=%h exp=%h", i, out_flit, pk[i]); end
         checks++; if (busy !== (i < 2)) begin failures++; $display("FAIL worm_busy%0d got=%b exp=%b", i, busy, (i < 2)); end
         checks++; if (err !== 1'b0) begin failures++; $display("FAIL worm_err%0d got=%b exp=0", i, err); end
      end
      tick();
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL worm_drain got=%b exp=0000", out_valid); end
   endtask

   task automatic test_singles();
      out_ready = 4'hF;
      in_flit = 12'hF12; in_valid = 1'b1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_rdy0 got=%b exp=1", in_ready); end
      tick();
      in_flit = 12'hC34;
      checks++; if (out_valid !== 4'b1000) begin failures++; $display("FAIL single_ov0 got=%b exp=1000", out_valid); end
      checks++; if (out_flit !== 12'hF12) begin failures++; $display("FAIL single_fl0 got=%h exp=F12", out_flit); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_rdy1 got=%b exp=1", in_ready); end
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b0001) begin failures++; $display("FAIL single_ov1 got=%b exp=0001", out_valid); end
      checks++; if (out_flit !== 12'hC34) begin failures++; $display("FAIL single_fl1 got=%h exp=C34", out_flit); end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 4'b1011;
      send(12'h6AB);
      in_flit = 12'h0CD; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_rdy%0d got=%b exp=0", i, in_ready); end
         checks++; if (out_flit !== 12'h6AB) begin failures++; $display("FAIL bp_flit%0d got=%h exp=6AB", i, out_flit); end
         checks++; if (out_valid !== 4'b0100) begin failures++; $display("FAIL bp_ov%0d got=%b exp=0100", i, out_valid); end
         tick();
      end
      out_ready = 4'hF;
      tick();
      checks++; if (out_flit !== 12'h0CD || out_valid !== 4'b0100) begin failures++; $display("FAIL bp_body got=%h/%b exp=0CD/0100", out_flit, out_valid); end
      send(12'h8EF);
      checks++; if (out_flit !== 12'h8EF || out_valid !== 4'b0100) begin failures++; $display("FAIL bp_tail got=%h/%b exp=8EF/0100", out_flit, out_valid); end
      tick();
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL bp_nodup got=%b exp=0000", out_valid); end
   endtask

   task automatic test_ignored_ready();
      out_ready = 4'b1101;
      send(12'hD44);
      in_flit = 12'hF12; in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++; if (out_valid !== 4'b0010 || out_flit !== 12'hD44) begin failures++; $display("FAIL ign_hold%0d got=%h/%b exp=D44/0010", i, out_flit, out_valid); end
         checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ign_rdy%0d got=%b exp=0", i, in_ready); end
      end
      out_ready = 4'hF;
      tick();
      in_valid = 1'b0;
      checks++; if (out_valid !== 4'b1000 || out_flit !== 12'hF12) begin failures++; $display("FAIL ign_next got=%h/%b exp=F12/1000", out_flit, out_valid); end
      tick();
   endtask

   task automatic test_errors();
      out_ready = 4'hF;
      send(12'h055);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_idle got=%b exp=1", err); end
      checks++; if (out_valid !== 4'b0000) begin failures++; $display("FAIL err_idle_ov got=%b exp=0000", out_valid); end
      tick();
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_pulse got=%b exp=0", err); end
      send(12'h5AA);
      checks++; if (out_valid !== 4'b0010 || busy !== 1'b1) begin failures++; $display("FAIL err_head got=%b/%b exp=0010/1", out_valid, busy); end
      send(12'h7BB);
      checks++; if (err !== 1'b1 || out_valid !== 4'b0000 || busy !== 1'b1) begin failures++; $display("FAIL err_locked got=%b/%b/%b exp=1/0000/1", err, out_valid, busy); end
      send(12'h811);
      checks++; if (out_valid !== 4'b0010 || out_flit !== 12'h811 || err !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL err_tail got=%b/%h/%b/%b exp=0010/811/0/0", out_valid, out_flit, err, busy); end
      tick();
   endtask

   task automatic test_reset_mid();
      out_ready = 4'hF;
      send(12'h6AB);
      send(12'h0CD);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #1;
      checks++; if (out_valid !== 4'b0000 || busy !== 1'b0 || err !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rstmid got=%b/%b/%b/%b exp=0000/0/0/1", out_valid, busy, err, in_ready); end
      send(12'hD99);
      checks++; if (out_valid !== 4'b0010 || out_flit !== 12'hD99 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_single got=%b/%h/%b exp=0010/D99/0", out_valid, out_flit, busy); end
      tick();
   endtask

   task automatic test_random();
      logic [1:0] t;
      bit         hold;
      hold = 0;
      for (int c = 0; c < 600; c++) begin
         if (!hold) begin
            in_valid = ($urandom_range(0, 3) != 0);
            t = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) :
                ((route < 0) ? (($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11)
                             : (($urandom_range(0, 2) != 0) ? 2'b00 : 2'b10));
            in_flit = {t, 10'($urandom)};
         end
         out_ready = 4'($urandom);
         #1;
         checks++; if (in_ready !== mdl_ready()) begin failures++; $display("FAIL rnd_rdy c=%0d got=%b exp=%b", c, in_ready, mdl_ready()); end
         hold = in_valid && !mdl_ready();
         tick();
         checks++; if (out_valid !== mdl_ovalid()) begin failures++; $display("FAIL rnd_ov c=%0d got=%b exp=%b", c, out_valid, mdl_ovalid()); end
         if (q.size() != 0) begin
            checks++; if (out_flit !== q[0].flit) begin failures++; $display("FAIL rnd_flit c=%0d got=%h exp=%h", c, out_flit, q[0].flit); end
         end
         checks++; if (busy !== (route >= 0)) begin failures++; $display("FAIL rnd_busy c=%0d got=%b exp=%b", c, busy, (route >= 0)); end
         checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err c=%0d got=%b exp=%b", c, err, m_err); end
      end
      in_valid = 1'b0;
      out_ready = 4'hF;
      tick();
   endtask

   initial begin
      checks = 0; failures = 0;
      route = -1; m_err = 0;
      reset_n = 1'b0; in_valid = 1'b0; in_flit = '0; out_ready = 4'hF;
      test_reset();
      test_wormhole();
      test_singles();
      test_backpressure();
      test_ignored_ready();
      test_errors();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
